// File: rtl/fsm3_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fsm3_pkg
// Shared types and constants for the scan controller.
//   - fsm_state_t  : encodings of the scanned 4-state Moore FSM (A..D)
//   - ctrl_state_t : controller states (IDLE / RUN / DONE)
//   - MAX_LEN_DEFAULT, DATA_W, LEN_W : frame sizing
//   - clamp_len()  : saturates a requested frame length to the maximum
// ---------------------------------------------------------------------------
package fsm3_pkg;

  localparam int MAX_LEN_DEFAULT = 16;
  localparam int DATA_W          = 16;
  localparam int LEN_W           = 5;

  typedef enum logic [1:0] {
    ST_A = 2'b00,
    ST_B = 2'b01,
    ST_C = 2'b10,
    ST_D = 2'b11
  } fsm_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'b00,
    CTRL_RUN  = 2'b01,
    CTRL_DONE = 2'b10
  } ctrl_state_t;

  // Requests longer than the frame buffer are scanned as a full frame.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req_len,
                                                 input int max_len);
    logic [LEN_W-1:0] result;
    result = req_len;
    if (int'(req_len) > max_len) begin
      result = LEN_W'(max_len);
    end
    return result;
  endfunction

endpackage

// File: rtl/fsm3_next_logic.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fsm3_next_logic
// Purely combinational next-state and Moore-output function of the scanned
// FSM. No storage; the state register lives in the controller.
// Ports:
//   i_in         : input bit being consumed this cycle
//   i_state      : current scanned-FSM state
//   o_next_state : state after consuming i_in
//   o_out        : Moore output, 1 only in state D (depends on i_state only)
// ---------------------------------------------------------------------------
module fsm3_next_logic
  import fsm3_pkg::*;
(
  input  logic       i_in,
  input  fsm_state_t i_state,
  output fsm_state_t o_next_state,
  output logic       o_out
);

  always_comb begin
    o_next_state = ST_A;
    case (i_state)
      ST_A:    o_next_state = i_in ? ST_B : ST_A;
      ST_B:    o_next_state = i_in ? ST_B : ST_C;
      ST_C:    o_next_state = i_in ? ST_D : ST_A;
      ST_D:    o_next_state = i_in ? ST_B : ST_C;
      default: o_next_state = ST_A;
    endcase
  end

  assign o_out = (i_state == ST_D);

endmodule

// File: rtl/fsm3_scan_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fsm3_scan_ctrl
// Feeds a captured frame, LSB first, one bit per clock into a 4-state Moore
// FSM and counts how many consumed bits left that FSM in state D.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   resetn    : synchronous active-low reset
//   start     : scan request, only looked at while idle
//   data_in   : frame bits (captured with an accepted start)
//   len       : frame length 0..16, larger values scan 16 bits
//   busy      : high while running or signalling completion
//   done      : one-cycle completion pulse
//   hit_count : number of bits after which the FSM was in state D
//   fsm_state : scanned-FSM state register
//   fsm_out   : Moore output of the scanned FSM (state D decode)
// ---------------------------------------------------------------------------
module fsm3_scan_ctrl
  import fsm3_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic [4:0]  len,
  output logic        busy,
  output logic        done,
  output logic [4:0]  hit_count,
  output logic [1:0]  fsm_state,
  output logic        fsm_out
);

  ctrl_state_t r_ctrl;
  ctrl_state_t w_ctrl_next;

  // Frame is held in a shift register so the bit under consumption is
  // always bit 0; the index only decides when the frame is finished.
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_next;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  w_idx_next;
  logic [LEN_W-1:0]  r_hit;
  logic [LEN_W-1:0]  w_hit_next;

  fsm_state_t r_fsm;
  fsm_state_t w_fsm_next;
  fsm_state_t w_scan_next;
  logic       w_scan_out;

  logic [LEN_W-1:0] w_len_clamped;
  logic             w_last_bit;

  assign w_len_clamped = clamp_len(len, MAX_LEN);

  // r_len is never 0 while running, so the subtraction cannot underflow.
  assign w_last_bit = (r_idx == (r_len - 5'd1));

  fsm3_next_logic u_next_logic (
    .i_in         (r_shift[0]),
    .i_state      (r_fsm),
    .o_next_state (w_scan_next),
    .o_out        (w_scan_out)
  );

  // -------------------------------------------------------------------------
  // Controller next-state and datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    w_ctrl_next  = r_ctrl;
    w_shift_next = r_shift;
    w_len_next   = r_len;
    w_idx_next   = r_idx;
    w_hit_next   = r_hit;
    w_fsm_next   = r_fsm;

    case (r_ctrl)
      CTRL_IDLE: begin
        if (start) begin
          w_fsm_next = ST_A;
          w_hit_next = '0;
          if (w_len_clamped != '0) begin
            w_shift_next = data_in;
            w_len_next   = w_len_clamped;
            w_idx_next   = '0;
            w_ctrl_next  = CTRL_RUN;
          end else begin
            // Empty frame: nothing to consume, report completion at once.
            w_ctrl_next = CTRL_DONE;
          end
        end
      end

      CTRL_RUN: begin
        w_fsm_next   = w_scan_next;
        w_shift_next = r_shift >> 1;
        w_idx_next   = r_idx + 5'd1;
        // A 16-bit frame reaches D at most 7 times, so 5 bits never wrap.
        if (w_scan_next == ST_D) begin
          w_hit_next = r_hit + 5'd1;
        end
        if (w_last_bit) begin
          w_ctrl_next = CTRL_DONE;
        end
      end

      CTRL_DONE: begin
        // start is deliberately not looked at here: no request queuing.
        w_ctrl_next = CTRL_IDLE;
      end

      default: begin
        w_ctrl_next = CTRL_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ctrl  <= CTRL_IDLE;
      r_shift <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_hit   <= '0;
      r_fsm   <= ST_A;
    end else begin
      r_ctrl  <= w_ctrl_next;
      r_shift <= w_shift_next;
      r_len   <= w_len_next;
      r_idx   <= w_idx_next;
      r_hit   <= w_hit_next;
      r_fsm   <= w_fsm_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy      = (r_ctrl == CTRL_RUN) || (r_ctrl == CTRL_DONE);
  assign done      = (r_ctrl == CTRL_DONE);
  assign hit_count = r_hit;
  assign fsm_state = r_fsm;
  assign fsm_out   = w_scan_out;

endmodule

// File: doc/fsm3_scan_ctrl.md
FSM3_SCAN_CTRL -- requirements
Module: fsm3_scan_ctrl

Interface
REQ-001 Parameter: MAX_LEN, default 16, maximum frame length in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a scan of one frame; sampled only in IDLE.
REQ-005 data_in  input  16  frame bits, consumed LSB first; captured when start is accepted.
REQ-006 len  input  5  frame length, 0..16; captured when start is accepted; values >16 SHALL be treated as 16.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 hit_count  output  5  number of bits after which the scanned FSM was in state D.
REQ-010 fsm_state  output  2  current scanned-FSM state register.
REQ-011 fsm_out  output  1  Moore output of the scanned FSM; 1 only in state D.

Function
REQ-012 The block SHALL own the state register of the 4-state Moore FSM: A=00, B=01, C=10, D=11.
REQ-013 Scanned-FSM next state, given input bit x: A: x0->A, x1->B; B: x0->C, x1->B; C: x0->A, x1->D; D: x0->C, x1->B.
REQ-014 Controller states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE with start=1 and len!=0: capture data_in and len; fsm_state<=A; hit_count<=0; bit index<=0; go to RUN.
REQ-016 IDLE with start=1 and len==0: hit_count<=0; fsm_state<=A; go to DONE directly.
REQ-017 RUN: each cycle, consume bit[index]; fsm_state<=next; if next==D, hit_count<=hit_count+1; index<=index+1.
REQ-018 RUN: on the edge that consumes the last bit (index==len-1), go to DONE.
REQ-019 For len=N>0, the N bits SHALL be consumed on edges 1..N after the start edge, and done SHALL be high for the cycle following edge N.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE; in DONE, start SHALL be ignored.
REQ-021 start during RUN or DONE SHALL be ignored; no queuing.
REQ-022 hit_count and fsm_state SHALL hold their final values in IDLE until the next accepted start.
REQ-023 hit_count SHALL be 5-bit unsigned and SHALL never wrap, because the maximum is 7 for 16 bits.
REQ-024 fsm_out SHALL be a combinational decode of fsm_state, with no added latency.

Reset
REQ-025 resetn=0 at a rising edge SHALL force: IDLE, fsm_state=A, hit_count=0, index=0, busy=0, done=0, fsm_out=0.
REQ-026 Reset mid-RUN SHALL abandon the frame with no done pulse; the first start after release SHALL be accepted normally.
REQ-027 Reset SHALL take priority over start in the same cycle.

Structure
REQ-028 Package fsm3_pkg SHALL hold the scanned-FSM state typedef and encodings (A..D), the controller state typedef (IDLE/RUN/DONE), and the MAX_LEN default.
REQ-029 Sub-module fsm3_next_logic SHALL hold the purely combinational next-state/out function (in, state -> next_state, out), instantiated once.
REQ-030 The top SHALL hold the controller FSM, shift/index counter, fsm_state register and hit counter.

Verification
REQ-031 data_in=16'h0005, len=3 -> states B,C,D on edges 1..3; done in the following cycle; hit_count=1; fsm_state=11.
REQ-032 data_in=16'h5555, len=16 -> D after bits 2,4,...,14; hit_count=7; done one cycle after edge 16.
REQ-033 data_in=16'hFFFF, len=16 -> fsm_state stays B after bit 0; hit_count=0; fsm_out never 1.
REQ-034 len=0 with start -> busy for one cycle; done=1 in that cycle; hit_count=0.
REQ-035 start re-asserted every cycle during a len=5 scan -> only one done; result is unaffected by the repeated starts.
REQ-036 resetn=0 at edge 2 of a len=8 scan -> no done; outputs return to reset values; a subsequent 16'h0005/len=3 scan -> hit_count=1.
